// File: rtl/approx_booth_mult16_pkg.sv
// Shared types, widths and helpers for the approximate radix-4 Booth multiplier.
package approx_mult_pkg;

  localparam int IN_W   = 16;
  localparam int OUT_W  = 32;
  localparam int NUM_PP = 8;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_e;

  // Mask keeping columns [OUT_W-1:vbl]; vbl=0 keeps every bit.
  function automatic logic [OUT_W-1:0] make_trunc_mask(input int vbl);
    logic [OUT_W-1:0] one;
    one = {{(OUT_W-1){1'b0}}, 1'b1};
    return ~((one << vbl) - one);
  endfunction

  // Group is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_e booth_decode(input logic [2:0] grp);
    booth_digit_e d;
    case (grp)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/approx_booth_mult16_booth_pp_gen.sv
// One radix-4 Booth partial product: digit * sext32(A), shifted left by SHIFT columns.
module booth_pp_gen
  import approx_mult_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic [IN_W-1:0]  a_i,
  input  logic [2:0]       grp_i,
  output logic [OUT_W-1:0] pp_o
);

  booth_digit_e     digit;
  logic [OUT_W-1:0] a_ext;
  logic [OUT_W-1:0] mag;

  always_comb begin
    digit = booth_decode(grp_i);
    a_ext = {{(OUT_W-IN_W){a_i[IN_W-1]}}, a_i};
    mag   = '0;
    // Negation is a full two's-complement negate, so no correction bits are needed later.
    case (digit)
      POS1:    mag = a_ext;
      POS2:    mag = a_ext << 1;
      NEG1:    mag = -a_ext;
      NEG2:    mag = -(a_ext << 1);
      default: mag = '0;
    endcase
    pp_o = mag << SHIFT;
  end

endmodule

// File: rtl/approx_booth_mult16.sv
// Signed 16x16 broken-booth approximate multiplier; partial-product columns below VBL are dropped.
module approx_booth_mult16
  import approx_mult_pkg::*;
#(
  parameter int VBL = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  A,
  input  logic signed [IN_W-1:0]  B,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out
);

  // Handshake: no backpressure. in_valid qualifies A/B at a rising edge; out_valid is
  // high for exactly the cycle after each accepted pair, and out holds between products.

  localparam logic [OUT_W-1:0] TRUNC_MASK = make_trunc_mask(VBL);

  logic [IN_W:0]    b_ext;
  logic [OUT_W-1:0] pp [NUM_PP];
  logic [OUT_W-1:0] sum;
  logic [OUT_W-1:0] out_d, out_q;
  logic             valid_d, valid_q;

  assign b_ext = {B, 1'b0};

  for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
    booth_pp_gen #(.SHIFT(2*i)) u_pp (
      .a_i   (A),
      .grp_i (b_ext[2*i+2 -: 3]),
      .pp_o  (pp[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      sum = sum + (pp[i] & TRUNC_MASK);
    end
    out_d   = in_valid ? sum : out_q;
    valid_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_approx_booth_mult16.sv
// Scoreboard bench for approx_booth_mult16: a VBL=10 and a VBL=0 instance share one stimulus stream.
module tb_approx_booth_mult16;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] a, b;
  logic               ov10, ov0;
  logic signed [31:0] out10, out0;

  typedef struct {
    logic        v;
    logic [31:0] o10;
    logic [31:0] o0;
    longint      exact;
    logic        has_k10;
    logic [31:0] k10;
    logic        has_k0;
    logic [31:0] k0;
    logic        stat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] held10 = '0;
  logic [31:0] held0  = '0;
  real         err_sum = 0.0, err_sq = 0.0;
  int          err_n = 0;

  approx_booth_mult16 #(.VBL(10)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
    .out_valid(ov10), .out(out10)
  );
  approx_booth_mult16 #(.VBL(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
    .out_valid(ov0), .out(out0)
  );

  always #5 clk = ~clk;

  // Reference: digit d_i = b[2i-1] + b[2i] - 2*b[2i+1]; M_i = (d_i*A*4^i) with low vbl bits cleared.
  function automatic logic [31:0] ref_mult(input logic signed [15:0] av,
                                           input logic [15:0] bv, input int vbl);
    logic [31:0] acc, p32, keep;
    longint      pp;
    int          d, bm1;
    acc  = '0;
    keep = 32'hFFFF_FFFF << vbl;
    for (int i = 0; i < 8; i++) begin
      bm1 = (i == 0) ? 0 : int'(bv[2*i-1]);
      d   = bm1 + int'(bv[2*i]) - 2 * int'(bv[2*i+1]);
      pp  = longint'(d) * longint'(av) * (longint'(1) <<< (2*i));
      p32 = pp[31:0];
      acc = acc + (p32 & keep);
    end
    return acc;
  endfunction

  task automatic step(input logic r, input logic v, input logic signed [15:0] av,
                      input logic signed [15:0] bv, input logic hk10, input logic [31:0] k10,
                      input logic hk0, input logic [31:0] k0, input logic st);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; a = av; b = bv;
    e = '{v: 1'b0, o10: '0, o0: '0, exact: 0, has_k10: hk10, k10: k10,
          has_k0: hk0, k0: k0, stat: st};
    if (r) begin
      held10 = '0; held0 = '0;
    end else if (v) begin
      held10 = ref_mult(av, bv, 10);
      held0  = ref_mult(av, bv, 0);
      e.v = 1'b1;
      e.exact = longint'(av) * longint'(bv);
    end
    e.o10 = held10;
    e.o0  = held0;
    exp_q.push_back(e);
  endtask

  task automatic rnd(input logic v, input logic st);
    step(1'b0, v, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
         1'b0, '0, 1'b0, '0, st);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (A=%0d B=%0d)", name, act, want, a, b);
    end
  endtask

  task automatic chk_err(input string name, input longint err, input longint lo, input longint hi);
    n_cmp++;
    if (err < lo || err > hi) begin
      n_bad++;
      $display("FAIL %s: error %0d outside [%0d, %0d]", name, err, lo, hi);
    end
  endtask

  // Monitor: one expected entry per cycle, sampled 1ns after the capturing edge.
  initial begin
    exp_t   e;
    longint err, e12;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("valid10", 32'(ov10), 32'(e.v));
        chk("valid0", 32'(ov0), 32'(e.v));
        chk("out10", out10, e.o10);
        chk("out0", out0, e.o0);
        if (e.has_k10) chk("directed10", out10, e.k10);
        if (e.has_k0)  chk("directed0", out0, e.k0);
        if (e.v) begin
          err = e.exact - longint'(out10);
          chk_err("bound10", err, 0, 8184);
          chk_err("exact0", e.exact - longint'(out0), 0, 0);
          if (e.stat) begin
            e12 = (e.exact >>> 12) - (longint'(out10) >>> 12);
            err_sum += real'(e12);
            err_sq  += real'(e12) * real'(e12);
            err_n++;
          end
        end
      end
    end
  end

  initial begin
    real mean, sd;
    int  waited;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    // Reset dominates in_valid.
    step(1'b1, 1'b1, 16'sd5, 16'sd7, 1'b1, 32'd0, 1'b1, 32'd0, 1'b0);
    step(1'b1, 1'b1, 16'sd5, 16'sd7, 1'b1, 32'd0, 1'b1, 32'd0, 1'b0);
    step(1'b0, 1'b0, 16'sd5, 16'sd7, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 16'sd5, 16'sd7, 1'b0, '0, 1'b0, '0, 1'b0);
    // Directed values.
    step(1'b0, 1'b1, 16'sd4096, 16'sd12288, 1'b1, 32'h0300_0000, 1'b1, 32'h0300_0000, 1'b0);
    step(1'b0, 1'b1, 16'sd1, 16'sd1, 1'b1, 32'd0, 1'b1, 32'd1, 1'b0);
    step(1'b0, 1'b1, -16'sd1, 16'sd1, 1'b1, 32'hFFFF_FC00, 1'b1, 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 1'b1, -16'sd32768, -16'sd32768, 1'b1, 32'd1073741824, 1'b1, 32'd1073741824, 1'b0);
    step(1'b0, 1'b1, 16'sd32767, -16'sd32768, 1'b1, -32'sd1073709056, 1'b1, -32'sd1073709056, 1'b0);
    step(1'b0, 1'b1, -16'sd1234, 16'sd567, 1'b0, '0, 1'b1, -32'sd699678, 1'b0);
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b0, '0, 1'b0, '0, 1'b0);
    // Alternating valid with holds, then a mid-stream reset.
    for (int i = 0; i < 20; i++) rnd(i[0] == 1'b0, 1'b0);
    rnd(1'b1, 1'b0);
    step(1'b1, 1'b1, 16'sd300, 16'sd300, 1'b1, 32'd0, 1'b1, 32'd0, 1'b0);
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1, 32'd0, 1'b1, 32'd0, 1'b0);
    for (int i = 0; i < 30; i++) rnd($urandom_range(0, 1) == 1, 1'b0);
    // Back-to-back random regression.
    for (int i = 0; i < 10000; i++) rnd(1'b1, 1'b1);
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b0, '0, 1'b0, '0, 1'b0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    n_cmp++;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end

    if (err_n > 0) begin
      mean = err_sum / real'(err_n);
      sd   = $sqrt(err_sq / real'(err_n) - mean * mean);
      $display("Q4.12 error (exact>>12 - out>>12) over %0d samples: mean %f std %f", err_n, mean, sd);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/approx_booth_mult16.md
Name: approx_booth_mult16

Overview:
- Signed 16x16 approximate multiplier producing a 32-bit two's-complement product.
- Uses radix-4 Booth recoding of B with a broken-booth truncation: partial-product bits below column VBL are discarded, trading accuracy for area.
- Sits in approximate-arithmetic datapaths using Q4.12 fixed point; consumers take the product >> 12.
- Single-cycle registered pipeline.

Parameters:
- VBL, 10, vertical break level: number of low columns (0..31) zeroed in every partial product; 0 gives an exact multiplier.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  A/B valid this cycle
- A  input  16  signed multiplicand
- B  input  16  signed multiplier (Booth-recoded)
- out_valid  output  1  out holds a new product
- out  output  32  signed approximate product

Behaviour:
- Reset: on a posedge with rst=1, out <= 0 and out_valid <= 0. rst has priority over in_valid.
- Latency: 1 cycle. A, B and in_valid are sampled at posedge N; out and out_valid update at posedge N. The product is visible after that edge.
- When in_valid=0 (and rst=0): out holds its previous value and out_valid <= 0.
- Booth recoding:
  - b[-1] = 0.
  - For i = 0..7, digit d_i is taken from (b[2i+1], b[2i], b[2i-1]): 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1.
  - B = sum of d_i * 4^i for every 16-bit signed B, including -32768.
- Partial products:
  - PP_i = (d_i * sext32(A)) << 2i, computed as an exact 32-bit two's-complement value, with negation fully applied (complement plus one).
- Truncation:
  - M_i = PP_i AND NOT(2^VBL - 1), i.e. bits [VBL-1:0] are forced to 0.
  - out = sum of M_0..M_7, modulo 2^32.
  - No rounding or compensation constant is added.
- Error properties, which verification must check:
  - Each M_i <= PP_i, so out <= exact product.
  - exact - out lies in [0, 8*(2^VBL - 1)].
  - With VBL=0, out equals the exact product for all inputs.
- No overflow exists: |A*B| <= 2^30 fits in 32 bits signed.
- Structure is combinational Booth encode, PP generation, masking and summation, followed by one output register. Any adder-tree form is acceptable provided the result is bit-exact to the definition above.

Decomposition:
- Shared package approx_mult_pkg:
  - Booth digit enum (ZERO, POS1, POS2, NEG1, NEG2)
  - widths IN_W=16, OUT_W=32, NUM_PP=8
  - function make_trunc_mask(VBL)
- One natural sub-module: booth_pp_gen. It takes A and a 3-bit Booth group and produces one 32-bit shifted partial product. It is instantiated 8 times, with the shift amount as a parameter.
- Top-level approx_booth_mult16 contains the masking, summation and output register.

Test Plan:
- Reset: rst=1 for 2 cycles while in_valid=1, A=5, B=7 -> out=0, out_valid=0; after rst drops, out_valid stays 0 until in_valid=1.
- No-error case, VBL=10: A=4096, B=12288 (1.0 x 3.0 in Q4.12) -> out=50331648 (0x03000000) one cycle later; out>>12 = 12288.
- Truncation floor, VBL=10:
  - A=1, B=1 -> out=0 (error -1).
  - A=-1, B=1 -> out=-1024 (0xFFFFFC00, error -1023).
- Exact mode, VBL=0:
  - A=-32768, B=-32768 -> out=1073741824.
  - A=32767, B=-32768 -> out=-1073709056.
  - A=-1234, B=567 -> out=-699678.
- Random regression, VBL=10: 10k random A, B with in_valid=1 every cycle -> each out satisfies 0 <= exact-out <= 8184. Report the mean and std of the error on out>>12 vs exact>>12.
- Hold and back-to-back:
  - Alternate in_valid 1/0 -> out_valid mirrors in_valid with 1-cycle delay and out holds during the gaps.
  - Assert rst mid-stream -> out=0 on the next edge.
